// File: rtl/pin_freq_meter.sv
// Input-capture peripheral: measures period, high time and rising-edge count
// of a square wave on meas_pin, in clk cycles, with timeout and interrupt.
module pin_freq_meter #(
    parameter int          ADDRWIDTH = 5,
    parameter logic [31:0] HW_VER    = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd,
    input  logic [ADDRWIDTH-1:0] raddr,
    output logic [31:0]          rdata,
    input  logic                 wr,
    input  logic [ADDRWIDTH-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic                 meas_pin,
    output logic                 irq
);

    localparam logic [ADDRWIDTH-1:0] A_VER     = ADDRWIDTH'(8'h00);
    localparam logic [ADDRWIDTH-1:0] A_CTRL    = ADDRWIDTH'(8'h04);
    localparam logic [ADDRWIDTH-1:0] A_PERIOD  = ADDRWIDTH'(8'h08);
    localparam logic [ADDRWIDTH-1:0] A_HIGH    = ADDRWIDTH'(8'h0C);
    localparam logic [ADDRWIDTH-1:0] A_EDGE    = ADDRWIDTH'(8'h10);
    localparam logic [ADDRWIDTH-1:0] A_TIMEOUT = ADDRWIDTH'(8'h14);
    localparam logic [ADDRWIDTH-1:0] A_STATUS  = ADDRWIDTH'(8'h18);
    localparam logic [ADDRWIDTH-1:0] A_CLR     = ADDRWIDTH'(8'h1C);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t      state, state_nxt;
    logic [2:0]  ctrl;
    logic [31:0] timeout_tar;
    logic        clr_pulse;

    logic [31:0] pcnt, pcnt_nxt;
    logic [31:0] hcnt, hcnt_nxt;
    logic [31:0] period, period_nxt;
    logic [31:0] high, high_nxt;
    logic [31:0] edge_cnt, edge_nxt;
    logic        valid, valid_nxt;
    logic        timeout, timeout_nxt;
    logic        overrun, overrun_nxt;
    logic        new_flag, new_nxt;

    logic        meas_p0, meas_p1, lvl_p2;
    logic        lvl, rise;
    logic        en, rd_period, tmo_hit;
    logic [32:0] pcnt_p1;

    assign en        = ctrl[0];
    assign lvl       = meas_p1 ^ ctrl[1];
    assign rise      = lvl & ~lvl_p2;
    assign rd_period = rd && (raddr == A_PERIOD);
    assign pcnt_p1   = {1'b0, pcnt} + 33'd1;
    assign tmo_hit   = (timeout_tar != 32'd0) && (pcnt_p1 >= {1'b0, timeout_tar});

    // Synchronize the pin, apply optional inversion, keep one delayed copy for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_p0 <= 1'b0;
            meas_p1 <= 1'b0;
            lvl_p2  <= 1'b0;
        end else begin
            meas_p0 <= meas_pin;
            meas_p1 <= meas_p0;
            lvl_p2  <= lvl;
        end
    end

    // CPU-writable configuration and the one-cycle clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl        <= 3'd0;
            timeout_tar <= 32'd0;
            clr_pulse   <= 1'b0;
        end else begin
            clr_pulse <= wr && (waddr == A_CLR) && wdata[0];
            if (wr && (waddr == A_CTRL))
                ctrl <= wdata[2:0];
            if (wr && (waddr == A_TIMEOUT))
                timeout_tar <= wdata;
        end
    end

    // Measurement state register and capture results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pcnt     <= 32'd0;
            hcnt     <= 32'd0;
            period   <= 32'd0;
            high     <= 32'd0;
            edge_cnt <= 32'd0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            overrun  <= 1'b0;
            new_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            pcnt     <= pcnt_nxt;
            hcnt     <= hcnt_nxt;
            period   <= period_nxt;
            high     <= high_nxt;
            edge_cnt <= edge_nxt;
            valid    <= valid_nxt;
            timeout  <= timeout_nxt;
            overrun  <= overrun_nxt;
            new_flag <= new_nxt;
        end
    end

    // Next state: clear beats disable, disable beats capture, capture beats timeout.
    always_comb begin
        state_nxt   = state;
        pcnt_nxt    = pcnt;
        hcnt_nxt    = hcnt;
        period_nxt  = period;
        high_nxt    = high;
        edge_nxt    = edge_cnt;
        valid_nxt   = valid;
        timeout_nxt = timeout;
        overrun_nxt = overrun;
        new_nxt     = rd_period ? 1'b0 : new_flag;

        if (clr_pulse) begin
            pcnt_nxt    = 32'd0;
            hcnt_nxt    = 32'd0;
            period_nxt  = 32'd0;
            high_nxt    = 32'd0;
            edge_nxt    = 32'd0;
            valid_nxt   = 1'b0;
            timeout_nxt = 1'b0;
            overrun_nxt = 1'b0;
            new_nxt     = 1'b0;
            state_nxt   = en ? WAIT_FIRST : IDLE;
        end else if (!en) begin
            state_nxt = IDLE;
            pcnt_nxt  = 32'd0;
            hcnt_nxt  = 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    pcnt_nxt  = 32'd0;
                    hcnt_nxt  = 32'd0;
                    state_nxt = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (rise) begin
                        pcnt_nxt  = 32'd0;
                        hcnt_nxt  = 32'd1;
                        edge_nxt  = sat_inc(edge_cnt);
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_nxt  = sat_inc(pcnt);
                        high_nxt    = hcnt;
                        valid_nxt   = 1'b1;
                        new_nxt     = 1'b1;
                        overrun_nxt = overrun | new_flag;
                        edge_nxt    = sat_inc(edge_cnt);
                        pcnt_nxt    = 32'd0;
                        hcnt_nxt    = 32'd1;
                    end else if (tmo_hit) begin
                        timeout_nxt = 1'b1;
                        valid_nxt   = 1'b0;
                        state_nxt   = WAIT_FIRST;
                    end else begin
                        pcnt_nxt = sat_inc(pcnt);
                        if (lvl)
                            hcnt_nxt = sat_inc(hcnt);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'd0;
        end else if (rd) begin
            case (raddr)
                A_VER:     rdata <= HW_VER;
                A_CTRL:    rdata <= {29'd0, ctrl};
                A_PERIOD:  rdata <= period;
                A_HIGH:    rdata <= high;
                A_EDGE:    rdata <= edge_cnt;
                A_TIMEOUT: rdata <= timeout_tar;
                A_STATUS:  rdata <= {28'd0, new_flag, overrun, timeout, valid};
                default:   rdata <= 32'd0;
            endcase
        end
    end

    // Level interrupt, one cycle behind the flags that drive it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else
            irq <= ctrl[2] & (new_flag | timeout);
    end

endmodule

// File: tb/tb_pin_freq_meter.sv
// Directed bench for pin_freq_meter with a timestamp-based reference model.
module tb_pin_freq_meter;

    logic        clk;
    logic        rst_n;
    logic        rd;
    logic [5:0]  raddr;
    logic [31:0] rdata;
    logic        wr;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        meas_pin;
    logic        irq;

    int total = 0;
    int bad   = 0;

    pin_freq_meter #(.ADDRWIDTH(6), .HW_VER(32'h0000_0001)) dut (
        .clk(clk), .rst_n(rst_n), .rd(rd), .raddr(raddr), .rdata(rdata),
        .wr(wr), .waddr(waddr), .wdata(wdata), .meas_pin(meas_pin), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the time of the last accepted rise and a history
    // of the conditioned level; period and high time are derived from those.
    int          cyc = 0;
    bit          hist [8192];
    logic [2:0]  m_ctrl;
    logic [31:0] m_tar, m_period, m_high, m_edges, m_rdata;
    bit          m_valid, m_tmo, m_ovr, m_new, m_irq, m_clrp;
    int          mode;     // 0 off, 1 armed (waiting first edge), 2 measuring
    int          t_rise;
    bit          q0, q1, pc;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ctrl = 0; m_tar = 0; m_period = 0; m_high = 0; m_edges = 0; m_rdata = 0;
            m_valid = 0; m_tmo = 0; m_ovr = 0; m_new = 0; m_irq = 0; m_clrp = 0;
            mode = 0; t_rise = 0; q0 = 0; q1 = 0; pc = 0;
        end else begin
            bit en, cond, rise, old_new, n_irq;
            logic [31:0] hsum;
            en = m_ctrl[0];
            cond = q1 ^ m_ctrl[1];
            rise = cond & ~pc;
            hist[cyc % 8192] = cond;
            if (rd) begin
                case (raddr)
                    6'h00: m_rdata = 32'h1;
                    6'h04: m_rdata = {29'd0, m_ctrl};
                    6'h08: m_rdata = m_period;
                    6'h0C: m_rdata = m_high;
                    6'h10: m_rdata = m_edges;
                    6'h14: m_rdata = m_tar;
                    6'h18: m_rdata = {28'd0, m_new, m_ovr, m_tmo, m_valid};
                    default: m_rdata = 0;
                endcase
            end
            n_irq = m_ctrl[2] & (m_new | m_tmo);
            old_new = m_new;
            if (rd && raddr == 6'h08) m_new = 0;
            if (m_clrp) begin
                m_period = 0; m_high = 0; m_edges = 0;
                m_valid = 0; m_tmo = 0; m_ovr = 0; m_new = 0;
                mode = en ? 1 : 0;
            end else if (!en) begin
                mode = 0;
            end else if (mode == 0) begin
                mode = 1;
            end else if (mode == 1) begin
                if (rise) begin
                    m_edges++; t_rise = cyc; mode = 2;
                end
            end else begin
                if (rise) begin
                    hsum = 0;
                    for (int t = t_rise; t < cyc; t++) hsum += 32'(hist[t % 8192]);
                    m_period = 32'(cyc - t_rise);
                    m_high = hsum;
                    m_valid = 1; m_new = 1; m_ovr = m_ovr | old_new;
                    m_edges++; t_rise = cyc;
                end else if (m_tar != 0 && 32'(cyc - t_rise) >= m_tar) begin
                    m_tmo = 1; m_valid = 0; mode = 1;
                end
            end
            m_clrp = wr && waddr == 6'h1C && wdata[0];
            if (wr && waddr == 6'h04) m_ctrl = wdata[2:0];
            if (wr && waddr == 6'h14) m_tar = wdata;
            q1 = q0; q0 = meas_pin; pc = cond;
            m_irq = n_irq;
        end
        cyc++;
    end

    // Every cycle: outputs against the model, or against reset values while in reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("cyc_rdata_rst", rdata, 32'd0);
            check("cyc_irq_rst", {31'd0, irq}, 32'd0);
        end else begin
            check("cyc_rdata", rdata, m_rdata);
            check("cyc_irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic do_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] v);
        @(negedge clk);
        rd = 1'b1; raddr = a;
        @(negedge clk);
        rd = 1'b0;
        v = rdata;
    endtask

    task automatic wave(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            meas_pin = 1'b1;
            repeat (hi) @(negedge clk);
            meas_pin = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int k;
        rst_n = 1'b0; rd = 0; raddr = 0; wr = 0; waddr = 0; wdata = 0; meas_pin = 0;
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Register map after reset
        do_read(6'h00, v); check("ver", v, 32'h1);
        do_read(6'h04, v); check("ctrl_rst", v, 32'd0);
        do_read(6'h18, v); check("status_rst", v, 32'd0);
        do_read(6'h1C, v); check("clr_reads0", v, 32'd0);
        do_read(6'h20, v); check("unmapped20", v, 32'd0);
        do_read(6'h02, v); check("unaligned02", v, 32'd0);

        // Basic measurement: 10-cycle period, 3 high
        do_write(6'h04, 32'h1);
        repeat (4) @(negedge clk);
        wave(5, 3, 7);
        do_read(6'h18, v); check("status_after_train", v, 32'd13);
        do_read(6'h10, v); check("edge_cnt5", v, 32'd5);
        do_read(6'h0C, v); check("high3", v, 32'd3);
        do_read(6'h08, v); check("period10", v, 32'd10);
        do_read(6'h18, v); check("status_new_cleared", v, 32'd5);

        // PERIOD read landing on the capture edge
        meas_pin = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd = 1'b1; raddr = 6'h08;
        @(negedge clk);
        rd = 1'b0;
        check("period_old_on_capture", rdata, 32'd10);
        meas_pin = 1'b0;
        do_read(6'h18, v); check("new_kept_on_capture_read", {31'd0, v[3]}, 32'd1);

        // Timeout
        do_write(6'h1C, 32'h1);
        do_write(6'h14, 32'd50);
        do_write(6'h04, 32'h5);
        repeat (3) @(negedge clk);
        meas_pin = 1'b1;
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (irq) begin k = i; break; end
            if (i == 3) meas_pin = 1'b0;
        end
        check("timeout_irq_latency", 32'(k), 32'd54);
        meas_pin = 1'b0;
        do_read(6'h18, v); check("status_timeout", v, 32'd2);
        do_read(6'h10, v); check("edge_after_timeout", v, 32'd1);
        do_read(6'h08, v); check("period_held", v, 32'd0);
        meas_pin = 1'b1; repeat (3) @(negedge clk);
        meas_pin = 1'b0; repeat (17) @(negedge clk);
        meas_pin = 1'b1; repeat (3) @(negedge clk);
        meas_pin = 1'b0; repeat (2) @(negedge clk);
        do_read(6'h18, v); check("status_recapture", v, 32'd11);
        do_read(6'h08, v); check("period20", v, 32'd20);
        do_read(6'h0C, v); check("high3_b", v, 32'd3);
        do_read(6'h10, v); check("edge3", v, 32'd3);

        // Inverted input with interrupt
        do_write(6'h1C, 32'h1);
        do_write(6'h14, 32'd0);
        do_write(6'h04, 32'h6);
        repeat (4) @(negedge clk);
        do_write(6'h1C, 32'h1);
        do_write(6'h04, 32'h7);
        repeat (4) @(negedge clk);
        wave(5, 3, 7);
        repeat (2) @(negedge clk);
        check("irq_set_inv", {31'd0, irq}, 32'd1);
        do_read(6'h08, v); check("period_inv", v, 32'd10);
        @(negedge clk);
        check("irq_clr_by_read", {31'd0, irq}, 32'd0);
        do_read(6'h0C, v); check("high_inv7", v, 32'd7);
        do_read(6'h10, v); check("edge_inv5", v, 32'd5);
        meas_pin = 1'b1; repeat (3) @(negedge clk);
        meas_pin = 1'b0; repeat (6) @(negedge clk);
        check("irq_set_again", {31'd0, irq}, 32'd1);
        do_write(6'h1C, 32'h1);
        repeat (2) @(negedge clk);
        check("irq_clr_by_clr", {31'd0, irq}, 32'd0);

        // Clear coinciding with a capture
        do_write(6'h04, 32'h1);
        repeat (4) @(negedge clk);
        wave(2, 3, 7);
        meas_pin = 1'b1;
        @(negedge clk);
        wr = 1'b1; waddr = 6'h1C; wdata = 32'h1;
        @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
        meas_pin = 1'b0;
        repeat (3) @(negedge clk);
        do_read(6'h08, v); check("clr_win_period", v, 32'd0);
        do_read(6'h0C, v); check("clr_win_high", v, 32'd0);
        do_read(6'h10, v); check("clr_win_edge", v, 32'd0);
        do_read(6'h18, v); check("clr_win_status", v, 32'd0);

        // Asynchronous reset mid-measurement
        do_write(6'h04, 32'h5);
        repeat (4) @(negedge clk);
        wave(3, 3, 7);
        do_read(6'h00, v);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        meas_pin = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        check("async_rst_rdata", rdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        meas_pin = 1'b0;
        do_read(6'h04, v); check("post_rst_ctrl", v, 32'd0);
        do_read(6'h18, v); check("post_rst_status", v, 32'd0);
        do_read(6'h10, v); check("post_rst_edge", v, 32'd0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
